// File: rtl/mips_pkg.sv
// Shared encodings for the multi-cycle MIPS subset: op codes, control FSM
// states and datapath mux select values.
package mips_pkg;

  typedef enum logic [2:0] {
    op_addu = 3'd0,
    op_subu = 3'd1,
    op_ori  = 3'd2,
    op_lw   = 3'd3,
    op_sw   = 3'd4,
    op_beq  = 3'd5,
    op_jal  = 3'd6,
    op_und  = 3'd7
  } op_e;

  typedef enum logic [2:0] {
    ST_IF   = 3'd0,
    ST_ID   = 3'd1,
    ST_EX   = 3'd2,
    ST_MEM  = 3'd3,
    ST_WB   = 3'd4,
    ST_TRAP = 3'd5
  } state_e;

  localparam logic [1:0] PC_SRC_SEQ = 2'd0;
  localparam logic [1:0] PC_SRC_BR  = 2'd1;
  localparam logic [1:0] PC_SRC_JMP = 2'd2;

  localparam logic [1:0] REG_DST_RT = 2'd0;
  localparam logic [1:0] REG_DST_RD = 2'd1;
  localparam logic [1:0] REG_DST_RA = 2'd2;

  localparam logic [1:0] WD_ALU = 2'd0;
  localparam logic [1:0] WD_MEM = 2'd1;
  localparam logic [1:0] WD_PC  = 2'd2;

  localparam logic [1:0] ALU_ADD = 2'd0;
  localparam logic [1:0] ALU_SUB = 2'd1;
  localparam logic [1:0] ALU_OR  = 2'd2;

endpackage

// File: rtl/mc_wait_timer.sv
// Memory handshake watchdog: expired fires on the WAIT_LIMIT-th consecutive
// waiting cycle. WAIT_LIMIT=0 removes the counter entirely.
module mc_wait_timer #(
  parameter int CNT_W      = 32,
  parameter int WAIT_LIMIT = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic req,
  input  logic ready,
  input  logic clear,
  output logic expired
);

  generate
    if (WAIT_LIMIT > 0) begin : g_timer
      localparam logic [CNT_W-1:0] LAST = CNT_W'(WAIT_LIMIT - 1);
      logic [CNT_W-1:0] r_cnt;

      // Count waiting cycles; any state change or ready restarts the count.
      always_ff @(posedge clk) begin
        if (reset) begin
          r_cnt <= {CNT_W{1'b0}};
        end else if (clear || ready) begin
          r_cnt <= {CNT_W{1'b0}};
        end else if (req) begin
          r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
          r_cnt <= r_cnt;
        end
      end

      assign expired = req && !ready && (r_cnt == LAST);
    end else begin : g_no_timer
      logic w_unused;
      assign w_unused = ^{clk, reset, req, ready, clear};
      assign expired  = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle control FSM for the 7-op MIPS subset. Define MC_CTRL_PERF_EN
// to add cycle_cnt / instret_cnt performance counters.
module mc_ctrl
  import mips_pkg::*;
#(
  parameter int CNT_W      = 32,
  parameter int WAIT_LIMIT = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] op,
  input  logic       zero,
  input  logic       imem_ready,
  input  logic       dmem_ready,
  output logic       imem_req,
  output logic       ir_we,
  output logic       pc_we,
  output logic [1:0] pc_src,
  output logic       reg_we,
  output logic [1:0] reg_dst,
  output logic [1:0] wd_src,
  output logic       alu_src,
  output logic       ext_op,
  output logic [1:0] alu_ctl,
  output logic       dmem_req,
  output logic       dmem_we,
  output logic       trap,
  output logic [2:0] state
`ifdef MC_CTRL_PERF_EN
  ,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
`endif
);

  state_e r_state;
  state_e w_next;
  op_e    r_op_q;
  logic   w_req;
  logic   w_ready;
  logic   w_expired;

  // Timer inputs come from the state register so they do not loop through w_next.
  assign w_req   = !reset && ((r_state == ST_IF) || (r_state == ST_MEM));
  assign w_ready = (r_state == ST_IF) ? imem_ready : dmem_ready;

  mc_wait_timer #(
    .CNT_W      (CNT_W),
    .WAIT_LIMIT (WAIT_LIMIT)
  ) u_wait_timer (
    .clk     (clk),
    .reset   (reset),
    .req     (w_req),
    .ready   (w_ready),
    .clear   (w_next != r_state),
    .expired (w_expired)
  );

  // State and latched op register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IF;
      r_op_q  <= op_und;
    end else begin
      r_state <= w_next;
      if (r_state == ST_ID) begin
        r_op_q <= op_e'(op);
      end else begin
        r_op_q <= r_op_q;
      end
    end
  end

  // Next-state and strobe decode; reset silences every output.
  always_comb begin
    w_next   = r_state;
    imem_req = 1'b0;
    ir_we    = 1'b0;
    pc_we    = 1'b0;
    pc_src   = PC_SRC_SEQ;
    reg_we   = 1'b0;
    reg_dst  = REG_DST_RT;
    wd_src   = WD_ALU;
    alu_src  = 1'b0;
    ext_op   = 1'b0;
    alu_ctl  = ALU_ADD;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    trap     = 1'b0;
    state    = 3'd0;
    if (reset) begin
      w_next = ST_IF;
    end else begin
      state = r_state;
      case (r_state)
        ST_IF: begin
          imem_req = 1'b1;
          if (imem_ready) begin
            ir_we  = 1'b1;
            pc_we  = 1'b1;
            w_next = ST_ID;
          end else if (w_expired) begin
            w_next = ST_TRAP;
          end else begin
            w_next = ST_IF;
          end
        end
        ST_ID: w_next = (op_e'(op) == op_und) ? ST_TRAP : ST_EX;
        ST_EX: begin
          case (r_op_q)
            op_addu: begin alu_ctl = ALU_ADD; w_next = ST_WB; end
            op_subu: begin alu_ctl = ALU_SUB; w_next = ST_WB; end
            op_ori: begin
              alu_ctl = ALU_OR;
              alu_src = 1'b1;
              w_next  = ST_WB;
            end
            op_lw, op_sw: begin
              alu_ctl = ALU_ADD;
              alu_src = 1'b1;
              ext_op  = 1'b1;
              w_next  = ST_MEM;
            end
            op_beq: begin
              alu_ctl = ALU_SUB;
              pc_we   = zero;
              pc_src  = PC_SRC_BR;
              w_next  = ST_IF;
            end
            op_jal: begin
              pc_we   = 1'b1;
              pc_src  = PC_SRC_JMP;
              reg_we  = 1'b1;
              reg_dst = REG_DST_RA;
              wd_src  = WD_PC;
              w_next  = ST_IF;
            end
            default: w_next = ST_TRAP;
          endcase
        end
        ST_MEM: begin
          dmem_req = 1'b1;
          dmem_we  = (r_op_q == op_sw);
          if (dmem_ready) begin
            w_next = (r_op_q == op_sw) ? ST_IF : ST_WB;
          end else if (w_expired) begin
            w_next = ST_TRAP;
          end else begin
            w_next = ST_MEM;
          end
        end
        ST_WB: begin
          reg_we = 1'b1;
          if (r_op_q == op_lw) begin
            wd_src = WD_MEM;
          end else if ((r_op_q == op_addu) || (r_op_q == op_subu)) begin
            reg_dst = REG_DST_RD;
          end else begin
            reg_dst = REG_DST_RT;
          end
          w_next = ST_IF;
        end
        ST_TRAP: begin
          trap   = 1'b1;
          w_next = ST_TRAP;
        end
        default: w_next = ST_IF;
      endcase
    end
  end

`ifdef MC_CTRL_PERF_EN
  // Retirement is the last cycle of an instruction, i.e. leaving for IF.
  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_cnt   <= {CNT_W{1'b0}};
      instret_cnt <= {CNT_W{1'b0}};
    end else begin
      if (r_state != ST_TRAP) begin
        cycle_cnt <= cycle_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        cycle_cnt <= cycle_cnt;
      end
      if ((r_state != ST_IF) && (w_next == ST_IF)) begin
        instret_cnt <= instret_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        instret_cnt <= instret_cnt;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed bench for mc_ctrl built with WAIT_LIMIT=4; every cycle's full
// strobe vector is compared against hand-derived values.
module tb_mc_ctrl;

  logic       clk = 1'b0;
  logic       reset, zero, imem_ready, dmem_ready;
  logic [2:0] op;
  logic       imem_req, ir_we, pc_we, reg_we, alu_src, ext_op, dmem_req, dmem_we, trap;
  logic [1:0] pc_src, reg_dst, wd_src, alu_ctl;
  logic [2:0] state;
`ifdef MC_CTRL_PERF_EN
  logic [31:0] cycle_cnt, instret_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mc_ctrl #(.CNT_W(32), .WAIT_LIMIT(4)) dut (
    .clk(clk), .reset(reset), .op(op), .zero(zero),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .imem_req(imem_req), .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src),
    .reg_we(reg_we), .reg_dst(reg_dst), .wd_src(wd_src), .alu_src(alu_src),
    .ext_op(ext_op), .alu_ctl(alu_ctl), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .trap(trap), .state(state)
`ifdef MC_CTRL_PERF_EN
    , .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
`endif
  );

  // Check the current cycle at the falling edge, then advance past the next rising edge.
  task automatic step(input string tag, input logic [2:0] st, input logic imr, input logic irw,
                      input logic pcw, input logic [1:0] pcs, input logic rw,
                      input logic [1:0] rd, input logic [1:0] wd, input logic as,
                      input logic eo, input logic [1:0] ac, input logic dr,
                      input logic dw, input logic tr);
    logic [19:0] obs, exp_v;
    @(negedge clk);
    obs   = {state, imem_req, ir_we, pc_we, pc_src, reg_we, reg_dst, wd_src,
             alu_src, ext_op, alu_ctl, dmem_req, dmem_we, trap};
    exp_v = {st, imr, irw, pcw, pcs, rw, rd, wd, as, eo, ac, dr, dw, tr};
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed %05h expected %05h", tag, obs, exp_v);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input string tag);
    step(tag, 3'd0, 1'b1, 1'b1, 1'b1, 2'd0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic decode(input string tag);
    step(tag, 3'd1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic quiet(input string tag);
    step(tag, 3'd0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    reset = 1'b1; op = 3'd7; zero = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    imem_ready = 1'b1;
    quiet("reset_quiet");
    reset = 1'b0;

    // addu: IF ID EX WB, back to IF on the 5th cycle
    op = 3'd0;
    fetch("addu_if"); decode("addu_id");
    step("addu_ex", 3'd2, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    step("addu_wb", 3'd4, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 2'd1, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);

    op = 3'd1;
    fetch("subu_if"); decode("subu_id");
    step("subu_ex", 3'd2, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0);
    step("subu_wb", 3'd4, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 2'd1, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);

    op = 3'd2;
    fetch("ori_if"); decode("ori_id");
    step("ori_ex", 3'd2, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 2'd0, 1'b1, 1'b0, 2'd2, 1'b0, 1'b0, 1'b0);
    step("ori_wb", 3'd4, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 2'd0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);

    // lw with 3 wait cycles: 8 cycles total
    op = 3'd3;
    fetch("lw_if"); decode("lw_id");
    step("lw_ex", 3'd2, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 2'd0, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++)
      step("lw_mem_wait", 3'd3, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0);
    dmem_ready = 1'b1;
    step("lw_mem_done", 3'd3, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0);
    step("lw_wb", 3'd4, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 2'd0, 2'd1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);

    op = 3'd4;
    fetch("sw_if"); decode("sw_id");
    step("sw_ex", 3'd2, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 2'd0, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0);
    step("sw_mem", 3'd3, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0);
    dmem_ready = 1'b0;

    op = 3'd5; zero = 1'b1;
    fetch("beq_t_if"); decode("beq_t_id");
    step("beq_taken_ex", 3'd2, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0);
    zero = 1'b0;
    fetch("beq_n_if"); decode("beq_n_id");
    step("beq_not_ex", 3'd2, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0);

    op = 3'd6;
    fetch("jal_if"); decode("jal_id");
    step("jal_ex", 3'd2, 1'b0, 1'b0, 1'b1, 2'd2, 1'b1, 2'd2, 2'd2, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);

    // undefined op traps and holds
    op = 3'd7;
    fetch("und_if"); decode("und_id");
    for (int i = 0; i < 20; i++)
      step("trap_hold", 3'd5, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
    reset = 1'b1;
    quiet("trap_reset");
    reset = 1'b0; imem_ready = 1'b0;

    // fetch timeout: 4 waiting IF cycles, then TRAP
    for (int i = 0; i < 4; i++)
      step("if_wait", 3'd0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    step("timeout_trap", 3'd5, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1);

    // reset in the middle of a data handshake
    reset = 1'b1;
    quiet("trap_reset2");
    reset = 1'b0; imem_ready = 1'b1; op = 3'd3;
    fetch("lw2_if"); decode("lw2_id");
    step("lw2_ex", 3'd2, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 2'd0, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0);
    step("lw2_mem", 3'd3, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0);
    reset = 1'b1;
    quiet("mem_reset_abort");
    reset = 1'b0; imem_ready = 1'b0;
    step("post_reset_if", 3'd0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
